// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter between the core
// load/store path and the program/data loader.
package dmem_arb_pkg;

   localparam int CNT_W = 4;

   typedef enum logic {
      CORE_PRI,
      LDR_FORCE
   } arb_state_e;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_CORE,
      OWN_LDR
   } owner_e;

endpackage

// File: rtl/dmem_arbiter_starve_ctr.sv
// Saturating count of consecutive loader denials; hit flags the
// last denial allowed before the loader must be forced through.
module arb_starve_ctr
   import dmem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic hit
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_MAX - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && cnt != LIMIT) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign hit = (cnt == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: core-priority grants, loader
// anti-starvation, synchronous read return tagged to the owner.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW         = 8,
   parameter int DW         = 8,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          core_req,
   input  logic          core_we,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wdata,
   output logic          core_gnt,
   output logic          core_rvalid,
   output logic [DW-1:0] core_rdata,
   output logic          stall,
   input  logic          ldr_req,
   input  logic          ldr_we,
   input  logic [AW-1:0] ldr_addr,
   input  logic [DW-1:0] ldr_wdata,
   output logic          ldr_gnt,
   output logic          ldr_rvalid,
   output logic [DW-1:0] ldr_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   arb_state_e state;
   arb_state_e state_nxt;
   owner_e     rd_owner;
   owner_e     owner_nxt;
   logic       live;
   logic       act;
   logic       hit;
   logic       inc;
   logic       clr;

   // Outputs stay quiet during reset and for one cycle after it.
   assign act = reset & live;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= CORE_PRI;
         rd_owner <= OWN_NONE;
         live     <= 1'b0;
      end else begin
         state    <= state_nxt;
         rd_owner <= owner_nxt;
         live     <= 1'b1;
      end
   end

   always_comb begin
      core_gnt  = 1'b0;
      ldr_gnt   = 1'b0;
      inc       = 1'b0;
      clr       = 1'b0;
      state_nxt = state;
      if (act) begin
         unique case (state)
            CORE_PRI: begin
               core_gnt = core_req;
               ldr_gnt  = ldr_req & ~core_req;
               if (ldr_req && core_req) begin
                  inc = 1'b1;
                  if (hit) state_nxt = LDR_FORCE;
               end
            end
            LDR_FORCE: begin
               ldr_gnt   = ldr_req;
               clr       = 1'b1;
               state_nxt = CORE_PRI;
            end
         endcase
      end
      if (ldr_gnt) clr = 1'b1;
   end

   arb_starve_ctr #(
      .STARVE_MAX(STARVE_MAX)
   ) u_starve (
      .clk  (clk),
      .reset(reset),
      .inc  (inc),
      .clr  (clr),
      .hit  (hit)
   );

   always_comb begin
      owner_nxt = OWN_NONE;
      if (core_gnt && !core_we) begin
         owner_nxt = OWN_CORE;
      end else if (ldr_gnt && !ldr_we) begin
         owner_nxt = OWN_LDR;
      end
   end

   always_comb begin
      mem_en    = core_gnt | ldr_gnt;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (core_gnt) begin
         mem_we    = core_we;
         mem_addr  = core_addr;
         mem_wdata = core_wdata;
      end else if (ldr_gnt) begin
         mem_we    = ldr_we;
         mem_addr  = ldr_addr;
         mem_wdata = ldr_wdata;
      end
   end

   assign stall       = act & core_req & ~core_gnt;
   assign core_rvalid = act & (rd_owner == OWN_CORE);
   assign ldr_rvalid  = act & (rd_owner == OWN_LDR);
   assign core_rdata  = core_rvalid ? mem_rdata : '0;
   assign ldr_rdata   = ldr_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised and directed checks of dmem_arbiter against a
// cycle-level behavioural model with a shadow memory.
module tb_dmem_arbiter;

   localparam int SMAX = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       core_req = 1'b0, core_we = 1'b0;
   logic [7:0] core_addr = '0, core_wdata = '0;
   logic       core_gnt, core_rvalid, stall;
   logic [7:0] core_rdata;
   logic       ldr_req = 1'b0, ldr_we = 1'b0;
   logic [7:0] ldr_addr = '0, ldr_wdata = '0;
   logic       ldr_gnt, ldr_rvalid;
   logic [7:0] ldr_rdata;
   logic       mem_en, mem_we;
   logic [7:0] mem_addr, mem_wdata;
   logic [7:0] mem_rdata = '0;

   always #5 clk = ~clk;

   dmem_arbiter #(.AW(8), .DW(8), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .reset(reset),
      .core_req(core_req), .core_we(core_we),
      .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(core_gnt), .core_rvalid(core_rvalid),
      .core_rdata(core_rdata), .stall(stall),
      .ldr_req(ldr_req), .ldr_we(ldr_we),
      .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid),
      .ldr_rdata(ldr_rdata),
      .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Environment memory: write at the grant edge, read data next cycle.
   logic [7:0] mem [256];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else mem_rdata <= mem[mem_addr];
      end
   end

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model state.
   logic [7:0] shadow [256];
   bit         m_live = 0;
   bit         m_force = 0;
   int         m_denied = 0;
   int         e_owner = 0;
   logic [7:0] e_data = '0;
   bit         mg_c, mg_l;
   logic       o_cg, o_lg, o_crv, o_stall;
   logic [7:0] o_crd;

   task automatic chk(input string nm, input logic [7:0] a,
                      input logic [7:0] e);
      n_vec++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h want %0h", nm, $time, a, e);
      end
   endtask

   task automatic step(input bit r,
                       input bit cr, input bit cw,
                       input logic [7:0] ca, input logic [7:0] cd,
                       input bit lr, input bit lw,
                       input logic [7:0] la, input logic [7:0] ld);
      bit act, e_en, e_we, e_crv, e_lrv, e_stall;
      logic [7:0] e_ad, e_wd, e_crd, e_lrd;
      int nxt_owner;
      logic [7:0] nxt_data;
      reset = r;
      core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
      ldr_req = lr; ldr_we = lw; ldr_addr = la; ldr_wdata = ld;
      #4;
      act = r && m_live;
      mg_c = 0; mg_l = 0;
      if (act) begin
         if (m_force) mg_l = lr;
         else begin
            mg_c = cr;
            mg_l = lr && !cr;
         end
      end
      e_stall = act && cr && !mg_c;
      e_en = mg_c || mg_l;
      e_we = mg_c ? cw : (mg_l ? lw : 1'b0);
      e_ad = mg_c ? ca : (mg_l ? la : 8'h00);
      e_wd = mg_c ? cd : (mg_l ? ld : 8'h00);
      e_crv = act && e_owner == 1;
      e_lrv = act && e_owner == 2;
      e_crd = e_crv ? e_data : 8'h00;
      e_lrd = e_lrv ? e_data : 8'h00;
      chk("core_gnt", {7'd0, core_gnt}, {7'd0, mg_c});
      chk("ldr_gnt", {7'd0, ldr_gnt}, {7'd0, mg_l});
      chk("stall", {7'd0, stall}, {7'd0, e_stall});
      chk("mem_en", {7'd0, mem_en}, {7'd0, e_en});
      chk("mem_we", {7'd0, mem_we}, {7'd0, e_we});
      chk("mem_addr", mem_addr, e_ad);
      chk("mem_wdata", mem_wdata, e_wd);
      chk("core_rvalid", {7'd0, core_rvalid}, {7'd0, e_crv});
      chk("core_rdata", core_rdata, e_crd);
      chk("ldr_rvalid", {7'd0, ldr_rvalid}, {7'd0, e_lrv});
      chk("ldr_rdata", ldr_rdata, e_lrd);
      o_cg = core_gnt; o_lg = ldr_gnt; o_stall = stall;
      o_crv = core_rvalid; o_crd = core_rdata;
      nxt_owner = 0; nxt_data = 8'h00;
      if (mg_c) begin
         if (cw) shadow[ca] = cd;
         else begin nxt_owner = 1; nxt_data = shadow[ca]; end
      end
      if (mg_l) begin
         if (lw) shadow[la] = ld;
         else begin nxt_owner = 2; nxt_data = shadow[la]; end
      end
      if (!r) begin
         m_live = 0; m_force = 0; m_denied = 0; e_owner = 0;
      end else begin
         if (act) begin
            if (m_force) begin
               m_force = 0; m_denied = 0;
            end else if (mg_l) begin
               m_denied = 0;
            end else if (lr) begin
               m_denied++;
               if (m_denied >= SMAX) m_force = 1;
            end
         end
         m_live = 1;
         e_owner = nxt_owner;
         e_data = nxt_data;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   string pat;
   bit pc, pcw, pl, plw;
   logic [7:0] pca, pcd, pla, pld;

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i] = 8'(i) ^ 8'hA5;
         shadow[i] = 8'(i) ^ 8'hA5;
      end
      @(posedge clk);
      #1;
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 8'h33, 0, 1, 0, 8'h44, 0);
      chk("reset_gnt", {6'd0, o_cg, o_lg}, 8'h00);
      step(1, 1, 0, 8'h33, 0, 1, 0, 8'h44, 0);
      chk("post_reset_quiet", {5'd0, o_cg, o_lg, o_stall}, 8'h00);
      idle(1);

      // Core-only write then read of 0x10.
      step(1, 1, 1, 8'h10, 8'h5A, 0, 0, 0, 0);
      chk("t1_wr_gnt", {7'd0, o_cg}, 8'h01);
      step(1, 1, 0, 8'h10, 0, 0, 0, 0, 0);
      chk("t1_rd_stall", {7'd0, o_stall}, 8'h00);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t1_rvalid", {7'd0, o_crv}, 8'h01);
      chk("t1_rdata", o_crd, 8'h5A);

      // Loader-only writes.
      for (int i = 0; i < 8; i++) begin
         step(1, 0, 0, 0, 0, 1, 1, 8'(i), 8'(8'h80 + i));
         chk("t2_ldr_gnt", {7'd0, o_lg}, 8'h01);
      end

      // Continuous contention.
      pat = "";
      for (int i = 0; i < 10; i++) begin
         step(1, 1, 1, 8'(8'h20 + i), 8'(i), 1, 1, 8'h30, 8'h77);
         pat = {pat, o_cg ? "C" : (o_lg ? "L" : "-")};
      end
      n_vec++;
      if (pat != "CCCCLCCCCL") begin
         n_err++;
         $display("FAIL t3_pattern: got %s want CCCCLCCCCL", pat);
      end

      // Back-to-back core reads of loader-written bytes.
      step(1, 1, 0, 8'h01, 0, 0, 0, 0, 0);
      step(1, 1, 0, 8'h02, 0, 0, 0, 0, 0);
      chk("t4_rd1", o_crd, 8'h81);
      step(1, 1, 0, 8'h03, 0, 0, 0, 0, 0);
      chk("t4_rd2", o_crd, 8'h82);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t4_rd3", o_crd, 8'h83);

      // Reset with a read in flight.
      step(1, 1, 0, 8'h10, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t5_no_rvalid", {7'd0, o_crv}, 8'h00);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t5_no_rvalid2", {7'd0, o_crv}, 8'h00);

      // Loader drops its request while forced.
      for (int i = 0; i < 4; i++) step(1, 1, 1, 8'h40, 8'h01, 1, 1, 8'h41, 8'h02);
      step(1, 1, 1, 8'h40, 8'h01, 0, 0, 0, 0);
      chk("t6_drop_gnt", {6'd0, o_cg, o_lg}, 8'h00);
      chk("t6_drop_stall", {7'd0, o_stall}, 8'h01);
      pat = "";
      for (int i = 0; i < 5; i++) begin
         step(1, 1, 1, 8'h40, 8'h01, 1, 1, 8'h41, 8'h02);
         pat = {pat, o_cg ? "C" : (o_lg ? "L" : "-")};
      end
      n_vec++;
      if (pat != "CCCCL") begin
         n_err++;
         $display("FAIL t6_pattern: got %s want CCCCL", pat);
      end

      // Random traffic with requests held until granted.
      pc = 0; pl = 0;
      for (int i = 0; i < 600; i++) begin
         if (!pc && $urandom_range(0, 2) != 0) begin
            pc = 1; pcw = 1'($urandom);
            pca = 8'($urandom_range(0, 15)); pcd = 8'($urandom);
         end
         if (!pl && $urandom_range(0, 2) == 0) begin
            pl = 1; plw = 1'($urandom);
            pla = 8'($urandom_range(0, 15)); pld = 8'($urandom);
         end
         if ($urandom_range(0, 99) == 0) begin
            step(0, pc, pcw, pca, pcd, pl, plw, pla, pld);
            pc = 0; pl = 0;
         end else begin
            step(1, pc, pcw, pca, pcd, pl, plw, pla, pld);
            if (mg_c) pc = 0;
            if (mg_l) pl = 0;
         end
      end
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
